fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program/data address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction and data word width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum memory wait cycles before fault.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, synchronous, active-high
- start  in  1  begin execution at start_pc
- start_pc  in  ADDR_W  execution start address
- cmd_valid  in  1  controller command present
- cmd  in  3  0=NEXT, 1=BRANCH, 2=LOAD, 3=STORE, 4=HALT; 5-7 reserved
- cmd_ready  out  1  command accepted this cycle
- br_off  in  ADDR_W  branch offset, two's complement
- addr_in  in  ADDR_W  data address for LOAD/STORE
- wdata_in  in  INSTR_W  STORE data
- ir  out  INSTR_W  instruction register
- ir_valid  out  1  ir holds the current instruction
- pc  out  ADDR_W  program counter
- rdata  out  INSTR_W  last LOAD result
- rdata_valid  out  1  one-cycle pulse, rdata updated
- mem_req  out  1  memory access request
- mem_we  out  1  write request when high
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  INSTR_W  memory write data
- mem_ready  in  1  memory completes the access this cycle
- mem_rdata  in  INSTR_W  memory read data, valid with mem_ready
- halted  out  1  in HALTED state
- fault  out  1  sticky memory timeout flag
- retired  out  16  retired-instruction count, saturating

Function
REQ-005 SHALL implement states IDLE, FETCH, EXEC, MEM, HALTED; mem_req, mem_we, mem_addr, cmd_ready, halted are decoded from state and registers only (Moore).
REQ-006 IDLE or HALTED with start=1 SHALL load pc<=start_pc, clear ir_valid, go FETCH; start is ignored in all other states.
REQ-007 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc; on mem_ready, ir<=mem_rdata, ir_valid<=1, go EXEC.
REQ-008 cmd_ready SHALL be 1 only in EXEC; cmd_valid outside EXEC SHALL have no effect.
REQ-009 EXEC NEXT SHALL set pc<=pc+1 modulo 2^ADDR_W, clear ir_valid, increment retired, go FETCH.
REQ-010 EXEC BRANCH SHALL set pc<=pc+br_off modulo 2^ADDR_W, clear ir_valid, increment retired, go FETCH.
REQ-011 EXEC LOAD/STORE SHALL capture addr_in into the data address register and wdata_in into the write-data register, go MEM; ir and pc unchanged.
REQ-012 MEM SHALL drive mem_req=1, mem_addr=data address register, mem_we=1 for STORE, mem_wdata=captured data; on mem_ready return to EXEC.
REQ-013 LOAD completion SHALL set rdata<=mem_rdata and assert rdata_valid for exactly the following cycle.
REQ-014 EXEC HALT SHALL increment retired, go HALTED; halted=1 while in HALTED.
REQ-015 Reserved cmd codes SHALL be accepted (cmd_ready=1) and treated as NEXT.
REQ-016 A wait counter SHALL clear on entry to FETCH/MEM and count each cycle mem_req=1 without mem_ready; at the TIMEOUT-th such cycle, fault<=1, ir_valid<=0, go HALTED.
REQ-017 mem_ready SHALL be ignored when mem_req=0; mem_ready in the first request cycle SHALL complete the access (zero wait states).
REQ-018 fault SHALL remain 1 until reset; start from HALTED with fault=1 SHALL resume execution with fault still 1.
REQ-019 retired SHALL saturate at 16'hFFFF.
REQ-020 Minimum loop SHALL be FETCH 1 cycle + EXEC 1 cycle per instruction with zero-wait memory.

Reset
REQ-021 rst_n=1 at a rising edge SHALL force state IDLE, pc=0, ir=0, ir_valid=0, data address and write-data registers=0, rdata=0, rdata_valid=0, fault=0, retired=0, wait counter=0.
REQ-022 Reset SHALL take priority over start, cmd_valid and mem_ready in the same cycle; an in-flight access is abandoned and mem_req is 0 from the cycle after the reset edge.

Verification
REQ-023 Reset, start=1, start_pc=8'h10, zero-wait memory returns 16'hA5A5 -> mem_addr=8'h10, ir=16'hA5A5, ir_valid=1 two cycles after start.
REQ-024 pc=8'hFF, NEXT -> pc=8'h00; pc=8'h05, BRANCH br_off=8'hFB -> pc=8'h00, retired incremented each time.
REQ-025 LOAD addr_in=8'h40, memory ready after 3 waits with 16'h1234 -> rdata=16'h1234, rdata_valid high one cycle, pc unchanged, retired unchanged.
REQ-026 STORE addr_in=8'h41, wdata_in=16'hBEEF -> mem_we=1, mem_addr=8'h41, mem_wdata=16'hBEEF until mem_ready, then EXEC.
REQ-027 FETCH with mem_ready held 0, TIMEOUT=15 -> fault=1, halted=1 after 15 request cycles; start then refetches from start_pc with fault=1.
REQ-028 Reset asserted in MEM with mem_ready=1 same cycle -> IDLE, rdata=0, rdata_valid=0, mem_req=0 next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and data access sequencer.
//
// Fetches one instruction word from pc into ir. It then waits in EXEC for a
// controller command: NEXT, BRANCH, LOAD, STORE or HALT. LOAD and STORE go
// through a single memory port that is shared with instruction fetch. A
// request that gets no answer within TIMEOUT cycles sets a sticky fault and
// parks the unit in HALTED.
//
// Ports:
//   clk, rst_n           clock and synchronous reset. rst_n is active-HIGH
//                        despite its name.
//   start, start_pc      begin execution at start_pc. Only honoured in IDLE
//                        or HALTED.
//   cmd_valid, cmd       controller command. 0=NEXT 1=BRANCH 2=LOAD 3=STORE
//                        4=HALT. Codes 5-7 are executed as NEXT.
//   cmd_ready            high in EXEC. The command is taken that cycle.
//   br_off               signed branch offset.
//   addr_in, wdata_in    data address and store data, captured with the
//                        LOAD/STORE command.
//   ir, ir_valid, pc     instruction register, its valid flag, and the
//                        program counter.
//   rdata, rdata_valid   last LOAD result. rdata_valid pulses for one cycle.
//   mem_*                memory request port. mem_ready completes an access.
//   halted, fault        HALTED state flag and the sticky timeout flag.
//   retired              retired-instruction count. Saturates at 16'hFFFF.
module fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  br_off,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [INSTR_W-1:0] wdata_in,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] rdata,
  output logic               rdata_valid,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               halted,
  output logic               fault,
  output logic [15:0]        retired
);

  // The wait counter only needs to reach TIMEOUT-1. The TIMEOUT-th miss
  // triggers the fault directly, without storing the count.
  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam logic [2:0] CMD_NEXT   = 3'd0;
  localparam logic [2:0] CMD_BRANCH = 3'd1;
  localparam logic [2:0] CMD_LOAD   = 3'd2;
  localparam logic [2:0] CMD_STORE  = 3'd3;
  localparam logic [2:0] CMD_HALT   = 3'd4;

  logic [2:0]         r_state,       w_state_d;
  logic [ADDR_W-1:0]  r_pc,          w_pc_d;
  logic [INSTR_W-1:0] r_ir,          w_ir_d;
  logic               r_ir_valid,    w_ir_valid_d;
  logic [ADDR_W-1:0]  r_daddr,       w_daddr_d;
  logic [INSTR_W-1:0] r_wdata,       w_wdata_d;
  logic               r_is_store,    w_is_store_d;
  logic [INSTR_W-1:0] r_rdata,       w_rdata_d;
  logic               r_rdata_valid, w_rdata_valid_d;
  logic               r_fault,       w_fault_d;
  logic [15:0]        r_retired,     w_retired_d;
  logic [WAIT_W-1:0]  r_wait,        w_wait_d;

  logic [15:0] w_retired_inc;
  logic        w_in_fetch;
  logic        w_in_mem;

  assign w_retired_inc = (r_retired == 16'hFFFF) ? r_retired : r_retired + 16'd1;
  assign w_in_fetch    = (r_state == ST_FETCH);
  assign w_in_mem      = (r_state == ST_MEM);

  always_comb begin
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_ir_d          = r_ir;
    w_ir_valid_d    = r_ir_valid;
    w_daddr_d       = r_daddr;
    w_wdata_d       = r_wdata;
    w_is_store_d    = r_is_store;
    w_rdata_d       = r_rdata;
    w_rdata_valid_d = 1'b0;
    w_fault_d       = r_fault;
    w_retired_d     = r_retired;
    w_wait_d        = r_wait;

    case (r_state)
      ST_IDLE, ST_HALTED: begin
        // The fault flag is deliberately not cleared here. Only reset clears it.
        if (start) begin
          w_pc_d       = start_pc;
          w_ir_valid_d = 1'b0;
          w_wait_d     = '0;
          w_state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (mem_ready) begin
          w_ir_d       = mem_rdata;
          w_ir_valid_d = 1'b1;
          w_state_d    = ST_EXEC;
        end else if (r_wait == WAIT_LAST) begin
          w_fault_d    = 1'b1;
          w_ir_valid_d = 1'b0;
          w_state_d    = ST_HALTED;
        end else begin
          w_wait_d = r_wait + WAIT_W'(1);
        end
      end

      ST_EXEC: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_BRANCH: begin
              w_pc_d       = r_pc + br_off;
              w_ir_valid_d = 1'b0;
              w_retired_d  = w_retired_inc;
              w_wait_d     = '0;
              w_state_d    = ST_FETCH;
            end
            CMD_LOAD, CMD_STORE: begin
              w_daddr_d    = addr_in;
              w_wdata_d    = wdata_in;
              w_is_store_d = (cmd == CMD_STORE);
              w_wait_d     = '0;
              w_state_d    = ST_MEM;
            end
            CMD_HALT: begin
              w_retired_d = w_retired_inc;
              w_state_d   = ST_HALTED;
            end
            // CMD_NEXT and the reserved codes 5-7 all advance to the next word.
            default: begin
              w_pc_d       = r_pc + ADDR_W'(1);
              w_ir_valid_d = 1'b0;
              w_retired_d  = w_retired_inc;
              w_wait_d     = '0;
              w_state_d    = ST_FETCH;
            end
          endcase
        end
      end

      ST_MEM: begin
        if (mem_ready) begin
          if (!r_is_store) begin
            w_rdata_d       = mem_rdata;
            w_rdata_valid_d = 1'b1;
          end
          w_state_d = ST_EXEC;
        end else if (r_wait == WAIT_LAST) begin
          w_fault_d    = 1'b1;
          w_ir_valid_d = 1'b0;
          w_state_d    = ST_HALTED;
        end else begin
          w_wait_d = r_wait + WAIT_W'(1);
        end
      end

      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_ir          <= '0;
      r_ir_valid    <= 1'b0;
      r_daddr       <= '0;
      r_wdata       <= '0;
      r_is_store    <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_retired     <= '0;
      r_wait        <= '0;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_ir          <= w_ir_d;
      r_ir_valid    <= w_ir_valid_d;
      r_daddr       <= w_daddr_d;
      r_wdata       <= w_wdata_d;
      r_is_store    <= w_is_store_d;
      r_rdata       <= w_rdata_d;
      r_rdata_valid <= w_rdata_valid_d;
      r_fault       <= w_fault_d;
      r_retired     <= w_retired_d;
      r_wait        <= w_wait_d;
    end
  end

  // Memory port and handshake outputs are decoded from registered state only.
  assign mem_req     = w_in_fetch | w_in_mem;
  assign mem_we      = w_in_mem & r_is_store;
  assign mem_addr    = w_in_mem ? r_daddr : r_pc;
  assign mem_wdata   = r_wdata;
  assign cmd_ready   = (r_state == ST_EXEC);
  assign halted      = (r_state == ST_HALTED);

  assign pc          = r_pc;
  assign ir          = r_ir;
  assign ir_valid    = r_ir_valid;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign fault       = r_fault;
  assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with default parameters
// (ADDR_W=8, INSTR_W=16, TIMEOUT=15).
//
// Expected instruction and load words are queued when the bench drives them
// onto mem_rdata. They are popped and compared when the DUT presents them on
// ir or rdata.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_pc;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic        cmd_ready;
  logic [7:0]  br_off;
  logic [7:0]  addr_in;
  logic [15:0] wdata_in;
  logic [15:0] ir;
  logic        ir_valid;
  logic [7:0]  pc;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] sb_q[$];
  logic [15:0] exp_v;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_pc   (start_pc),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .br_off     (br_off),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .halted     (halted),
    .fault      (fault),
    .retired    (retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b1; start = 1'b0; start_pc = 8'h00; cmd_valid = 1'b0; cmd = 3'd0;
    br_off = 8'h00; addr_in = 8'h00; wdata_in = 16'h0000; mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  task automatic start_at(input logic [7:0] a);
    start = 1'b1; start_pc = a;
    tick();
    start = 1'b0;
  endtask

  // One-cycle memory completion. When push is set, the word is queued as the
  // value the DUT should later present on ir or rdata.
  task automatic mem_resp(input logic [15:0] d, input logic push);
    mem_ready = 1'b1; mem_rdata = d;
    if (push) sb_q.push_back(d);
    tick();
    mem_ready = 1'b0; mem_rdata = 16'h0000;
  endtask

  task automatic exec_cmd(input logic [2:0] c, input logic [7:0] off, input logic [7:0] a,
                          input logic [15:0] wd);
    cmd_valid = 1'b1; cmd = c; br_off = off; addr_in = a; wdata_in = wd;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_vec++; if (pc !== 8'h00) begin $display("FAIL reset_pc: got %h want 00", pc); n_err++; end
    n_vec++; if ({ir, ir_valid} !== 17'h0) begin
      $display("FAIL reset_ir: got %h/%b want 0000/0", ir, ir_valid); n_err++; end
    n_vec++; if ({rdata, rdata_valid} !== 17'h0) begin
      $display("FAIL reset_rdata: got %h/%b want 0000/0", rdata, rdata_valid); n_err++; end
    n_vec++; if ({fault, retired} !== 17'h0) begin
      $display("FAIL reset_fault_ret: got %b/%h want 0/0000", fault, retired); n_err++; end
    n_vec++; if ({mem_req, halted, cmd_ready} !== 3'b000) begin
      $display("FAIL reset_decode: got %b want 000", {mem_req, halted, cmd_ready}); n_err++; end
    // Commands and memory responses in IDLE must be ignored.
    exec_cmd(3'd0, 8'h00, 8'h00, 16'h0000);
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    mem_ready = 1'b0;
    n_vec++; if ({pc, retired, ir_valid, ir} !== 41'h0) begin
      $display("FAIL idle_ignore: got pc=%h ret=%h irv=%b ir=%h want all 0", pc, retired,
               ir_valid, ir); n_err++; end
  endtask

  task automatic test_start();
    reset_dut();
    start_at(8'h10);
    n_vec++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h10}) begin
      $display("FAIL start_fetch: got req=%b we=%b addr=%h want 1/0/10", mem_req, mem_we,
               mem_addr); n_err++; end
    mem_resp(16'hA5A5, 1'b1);
    n_vec++;
    if (sb_q.size() == 0) begin $display("FAIL start_ir: got %h, queue empty", ir); n_err++; end
    else begin
      exp_v = sb_q.pop_front();
      if (ir !== exp_v) begin $display("FAIL start_ir: got %h want %h", ir, exp_v); n_err++; end
    end
    n_vec++; if ({ir_valid, cmd_ready, pc} !== {2'b11, 8'h10}) begin
      $display("FAIL start_exec: got irv=%b rdy=%b pc=%h want 1/1/10", ir_valid, cmd_ready, pc);
      n_err++; end
    // start is ignored outside IDLE/HALTED.
    start = 1'b1; start_pc = 8'h77;
    tick();
    start = 1'b0;
    n_vec++; if ({pc, cmd_ready} !== {8'h10, 1'b1}) begin
      $display("FAIL start_ignored: got pc=%h rdy=%b want 10/1", pc, cmd_ready); n_err++; end
  endtask

  task automatic test_pc_update();
    reset_dut();
    start_at(8'hFF);
    mem_resp(16'h0001, 1'b0);
    exec_cmd(3'd0, 8'h00, 8'h00, 16'h0000);
    n_vec++; if ({pc, retired, ir_valid, mem_addr} !== {8'h00, 16'd1, 1'b0, 8'h00}) begin
      $display("FAIL next_wrap: got pc=%h ret=%h irv=%b addr=%h want 00/0001/0/00", pc, retired,
               ir_valid, mem_addr); n_err++; end
    // Commands during FETCH must be ignored.
    exec_cmd(3'd1, 8'h10, 8'h00, 16'h0000);
    n_vec++; if ({pc, retired, mem_req} !== {8'h00, 16'd1, 1'b1}) begin
      $display("FAIL cmd_in_fetch: got pc=%h ret=%h req=%b want 00/0001/1", pc, retired, mem_req);
      n_err++; end
    reset_dut();
    start_at(8'h05);
    mem_resp(16'h0002, 1'b0);
    exec_cmd(3'd1, 8'hFB, 8'h00, 16'h0000);
    n_vec++; if ({pc, retired} !== {8'h00, 16'd1}) begin
      $display("FAIL branch_neg: got pc=%h ret=%h want 00/0001", pc, retired); n_err++; end
    mem_resp(16'h0003, 1'b0);
    exec_cmd(3'd5, 8'h40, 8'h00, 16'h0000);
    n_vec++; if ({pc, retired} !== {8'h01, 16'd2}) begin
      $display("FAIL reserved_cmd: got pc=%h ret=%h want 01/0002", pc, retired); n_err++; end
  endtask

  task automatic test_load();
    reset_dut();
    start_at(8'h20);
    mem_resp(16'hC0DE, 1'b0);
    exec_cmd(3'd2, 8'h00, 8'h40, 16'h0000);
    n_vec++; if ({mem_req, mem_we, mem_addr, cmd_ready} !== {2'b10, 8'h40, 1'b0}) begin
      $display("FAIL load_req: got req=%b we=%b addr=%h rdy=%b want 1/0/40/0", mem_req, mem_we,
               mem_addr, cmd_ready); n_err++; end
    repeat (3) tick();
    n_vec++; if ({mem_req, mem_addr} !== {1'b1, 8'h40}) begin
      $display("FAIL load_wait: got req=%b addr=%h want 1/40", mem_req, mem_addr); n_err++; end
    mem_resp(16'h1234, 1'b1);
    n_vec++; if (rdata_valid !== 1'b1) begin
      $display("FAIL load_valid: got %b want 1", rdata_valid); n_err++; end
    n_vec++;
    if (sb_q.size() == 0) begin $display("FAIL load_rdata: got %h, queue empty", rdata); n_err++; end
    else begin
      exp_v = sb_q.pop_front();
      if (rdata !== exp_v) begin $display("FAIL load_rdata: got %h want %h", rdata, exp_v); n_err++; end
    end
    n_vec++; if ({pc, retired, ir, cmd_ready} !== {8'h20, 16'd0, 16'hC0DE, 1'b1}) begin
      $display("FAIL load_state: got pc=%h ret=%h ir=%h rdy=%b want 20/0000/c0de/1", pc, retired,
               ir, cmd_ready); n_err++; end
    tick();
    n_vec++; if ({rdata_valid, rdata} !== {1'b0, 16'h1234}) begin
      $display("FAIL load_pulse: got v=%b d=%h want 0/1234", rdata_valid, rdata); n_err++; end
  endtask

  task automatic test_store();
    exec_cmd(3'd3, 8'h00, 8'h41, 16'hBEEF);
    addr_in = 8'h00; wdata_in = 16'h0000;
    n_vec++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h41, 16'hBEEF}) begin
      $display("FAIL store_req: got req=%b we=%b addr=%h wd=%h want 1/1/41/beef", mem_req, mem_we,
               mem_addr, mem_wdata); n_err++; end
    repeat (2) tick();
    n_vec++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h41, 16'hBEEF}) begin
      $display("FAIL store_hold: got we=%b addr=%h wd=%h want 1/41/beef", mem_we, mem_addr,
               mem_wdata); n_err++; end
    mem_resp(16'h0000, 1'b0);
    n_vec++; if ({cmd_ready, mem_req, rdata_valid, rdata} !== {3'b100, 16'h1234}) begin
      $display("FAIL store_done: got rdy=%b req=%b v=%b d=%h want 1/0/0/1234", cmd_ready, mem_req,
               rdata_valid, rdata); n_err++; end
  endtask

  task automatic test_halt();
    exec_cmd(3'd4, 8'h00, 8'h00, 16'h0000);
    n_vec++; if ({halted, retired, mem_req, cmd_ready} !== {1'b1, 16'd1, 2'b00}) begin
      $display("FAIL halt: got h=%b ret=%h req=%b rdy=%b want 1/0001/0/0", halted, retired,
               mem_req, cmd_ready); n_err++; end
    exec_cmd(3'd0, 8'h00, 8'h00, 16'h0000);
    n_vec++; if ({halted, retired, pc} !== {1'b1, 16'd1, 8'h20}) begin
      $display("FAIL halt_ignore: got h=%b ret=%h pc=%h want 1/0001/20", halted, retired, pc);
      n_err++; end
    start_at(8'h60);
    n_vec++; if ({halted, mem_req, mem_addr} !== {2'b01, 8'h60}) begin
      $display("FAIL halt_restart: got h=%b req=%b addr=%h want 0/1/60", halted, mem_req, mem_addr);
      n_err++; end
  endtask

  task automatic test_timeout();
    reset_dut();
    start_at(8'h30);
    repeat (14) tick();
    n_vec++; if ({fault, halted, mem_req} !== 3'b001) begin
      $display("FAIL timeout_early: got f=%b h=%b req=%b want 0/0/1", fault, halted, mem_req);
      n_err++; end
    tick();
    n_vec++; if ({fault, halted, ir_valid, mem_req} !== 4'b1100) begin
      $display("FAIL timeout: got f=%b h=%b irv=%b req=%b want 1/1/0/0", fault, halted, ir_valid,
               mem_req); n_err++; end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_vec++; if ({halted, ir_valid} !== 2'b10) begin
      $display("FAIL ready_no_req: got h=%b irv=%b want 1/0", halted, ir_valid); n_err++; end
    start_at(8'h50);
    n_vec++; if ({mem_req, mem_addr, fault} !== {1'b1, 8'h50, 1'b1}) begin
      $display("FAIL fault_resume: got req=%b addr=%h f=%b want 1/50/1", mem_req, mem_addr, fault);
      n_err++; end
    mem_resp(16'h5555, 1'b1);
    n_vec++;
    if (sb_q.size() == 0) begin $display("FAIL fault_ir: got %h, queue empty", ir); n_err++; end
    else begin
      exp_v = sb_q.pop_front();
      if ({ir, ir_valid, fault} !== {exp_v, 2'b11}) begin
        $display("FAIL fault_ir: got %h/%b/%b want %h/1/1", ir, ir_valid, fault, exp_v); n_err++; end
    end
  endtask

  task automatic test_reset_in_mem();
    reset_dut();
    start_at(8'h12);
    mem_resp(16'h0000, 1'b0);
    exec_cmd(3'd2, 8'h00, 8'h44, 16'h0000);
    mem_resp(16'h9999, 1'b1);
    n_vec++;
    if (sb_q.size() == 0) begin $display("FAIL pre_rst_load: got %h, queue empty", rdata); n_err++; end
    else begin
      exp_v = sb_q.pop_front();
      if (rdata !== exp_v) begin $display("FAIL pre_rst_load: got %h want %h", rdata, exp_v); n_err++; end
    end
    exec_cmd(3'd2, 8'h00, 8'h45, 16'h0000);
    rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick();
    rst_n = 1'b0; mem_ready = 1'b0;
    n_vec++; if ({mem_req, rdata, rdata_valid, pc, cmd_ready, halted} !== 29'h0) begin
      $display("FAIL rst_in_mem: got req=%b d=%h v=%b pc=%h rdy=%b h=%b want all 0", mem_req, rdata,
               rdata_valid, pc, cmd_ready, halted); n_err++; end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    start_at(8'h80);
    for (int i = 0; i < 4; i++) begin
      mem_resp(16'h0100 + 16'(i), 1'b1);
      n_vec++;
      if (sb_q.size() == 0) begin $display("FAIL b2b_ir[%0d]: got %h, queue empty", i, ir); n_err++; end
      else begin
        exp_v = sb_q.pop_front();
        if (ir !== exp_v) begin $display("FAIL b2b_ir[%0d]: got %h want %h", i, ir, exp_v); n_err++; end
      end
      exec_cmd(3'd0, 8'h00, 8'h00, 16'h0000);
      n_vec++;
      if ({pc, retired, mem_req} !== {8'h80 + 8'(i + 1), 16'(i + 1), 1'b1}) begin
        $display("FAIL b2b_pc[%0d]: got pc=%h ret=%h req=%b want %h/%h/1", i, pc, retired, mem_req,
                 8'h80 + 8'(i + 1), 16'(i + 1)); n_err++; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_pc_update();
    test_load();
    test_store();
    test_halt();
    test_timeout();
    test_reset_in_mem();
    test_back_to_back();
    n_vec++; if (sb_q.size() != 0) begin
      $display("FAIL sb_drain: got %0d entries left want 0", sb_q.size()); n_err++; end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
